// File: rtl/uart_tx.sv
// Serial transmitter: start bit, DATA_BITS payload LSB first, optional even parity, stop bit.
// Idle line is high; tx_empty signals readiness and tx_done pulses once per completed frame.
module uart_tx #(
  parameter int DATA_BITS    = 2,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0
) (
  input  logic                 txclk,
  input  logic                 reset,
  input  logic                 ld_tx_data,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_enable,
  output logic                 tx_out,
  output logic                 tx_empty,
  output logic                 tx_done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] sh_q, sh_d;
  logic                 par_q, par_d;
  logic                 out_d, empty_d, done_d;
  logic                 cnt_last;

  assign cnt_last = (cnt_q == CNT_LAST);

  always_ff @(posedge txclk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      sh_q     <= '0;
      par_q    <= 1'b0;
      tx_out   <= 1'b1;
      tx_empty <= 1'b1;
      tx_done  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      sh_q     <= sh_d;
      par_q    <= par_d;
      tx_out   <= out_d;
      tx_empty <= empty_d;
      tx_done  <= done_d;
    end
  end

  // Each branch computes the value tx_out takes for the next bit period, so the
  // line itself is always a flop output and the start bit appears on the load edge.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    par_d   = par_q;
    out_d   = tx_out;
    empty_d = tx_empty;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        out_d = 1'b1;
        if (ld_tx_data && tx_enable && tx_empty) begin
          sh_d    = tx_data;
          par_d   = ^tx_data;
          cnt_d   = '0;
          bit_d   = '0;
          out_d   = 1'b0;
          empty_d = 1'b0;
          state_d = START;
        end
      end
      START: begin
        if (cnt_last) begin
          cnt_d   = '0;
          out_d   = sh_q[0];
          sh_d    = sh_q >> 1;
          state_d = DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (cnt_last) begin
          cnt_d = '0;
          if (bit_q == BIT_LAST) begin
            bit_d = '0;
            if (PARITY_EN != 0) begin
              out_d   = par_q;
              state_d = PARITY;
            end else begin
              out_d   = 1'b1;
              state_d = STOP;
            end
          end else begin
            bit_d = bit_q + 1'b1;
            out_d = sh_q[0];
            sh_d  = sh_q >> 1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      PARITY: begin
        if (cnt_last) begin
          cnt_d   = '0;
          out_d   = 1'b1;
          state_d = STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STOP: begin
        if (cnt_last) begin
          cnt_d   = '0;
          out_d   = 1'b1;
          empty_d = 1'b1;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        out_d   = 1'b1;
        empty_d = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: stimulus queues hand-written serial frames, a negedge
// monitor per instance checks every bit period, the done pulse and the idle line.
module tb_uart_tx;

  logic       txclk;
  logic       reset;
  logic       ld0, en0, ld1, en1;
  logic [1:0] data0, data1;
  logic       tx_out0, tx_empty0, tx_done0;
  logic       tx_out1, tx_empty1, tx_done1;

  int tests = 0;
  int fails = 0;

  // bits[i] is the i-th serial bit in time order, start bit first
  typedef struct {
    logic [7:0] bits;
    int         nb;
    bit         aborted;
    string      name;
  } frame_t;

  frame_t q0[$];
  frame_t q1[$];

  frame_t cur[2];
  bit     in_frame[2];
  bit     skip[2];
  int     k[2];
  bit     bit_bad[2];
  logic   bad_val[2];
  int     done_cnt[2];
  int     idle_bad[2];

  uart_tx #(.DATA_BITS(2), .CLKS_PER_BIT(16), .PARITY_EN(0)) dut0 (
    .txclk(txclk), .reset(reset), .ld_tx_data(ld0), .tx_data(data0),
    .tx_enable(en0), .tx_out(tx_out0), .tx_empty(tx_empty0), .tx_done(tx_done0)
  );

  uart_tx #(.DATA_BITS(2), .CLKS_PER_BIT(16), .PARITY_EN(1)) dut1 (
    .txclk(txclk), .reset(reset), .ld_tx_data(ld1), .tx_data(data1),
    .tx_enable(en1), .tx_out(tx_out1), .tx_empty(tx_empty1), .tx_done(tx_done1)
  );

  initial begin
    txclk = 1'b0;
    forever #10 txclk = ~txclk;
  end

  task automatic check(input string name, input logic got, input logic exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %b, expected %b", name, got, exp);
    end
  endtask

  task automatic mon(input int u, input logic o, input logic e, input logic d);
    if (d === 1'b1) done_cnt[u]++;
    if (reset) begin
      if (in_frame[u]) begin
        tests++;
        if (!cur[u].aborted) begin
          fails++;
          $display("FAIL %s: frame cut by reset at sample %0d, expected completion", cur[u].name, k[u]);
        end
        in_frame[u] = 1'b0;
      end
      skip[u] = 1'b0;
      return;
    end
    if (in_frame[u] && k[u] == cur[u].nb * 16 + 1) begin
      tests++;
      if (d !== 1'b0 || cur[u].aborted) begin
        fails++;
        $display("FAIL %s end: tx_done=%b (expected 0), aborted-record=%0d (expected 0)",
                 cur[u].name, d, cur[u].aborted);
      end
      in_frame[u] = 1'b0;
    end
    if (!in_frame[u]) begin
      if (skip[u]) begin
        if (e === 1'b1) skip[u] = 1'b0;
      end else if (e === 1'b0) begin
        if ((u == 0 && q0.size() == 0) || (u == 1 && q1.size() == 0)) begin
          tests++;
          fails++;
          $display("FAIL unit%0d unexpected frame: tx_empty=0, expected 1 (no load pending)", u);
          skip[u] = 1'b1;
        end else begin
          cur[u]      = (u == 0) ? q0.pop_front() : q1.pop_front();
          in_frame[u] = 1'b1;
          k[u]        = 0;
          bit_bad[u]  = 1'b0;
        end
      end else if (o !== 1'b1) begin
        idle_bad[u]++;
      end
    end
    if (in_frame[u]) begin
      if (k[u] < cur[u].nb * 16) begin
        if (o !== cur[u].bits[k[u] / 16] || e !== 1'b0 || d !== 1'b0) begin
          bit_bad[u] = 1'b1;
          bad_val[u] = o;
        end
        if (k[u] % 16 == 15) begin
          tests++;
          if (bit_bad[u]) begin
            fails++;
            $display("FAIL %s bit%0d: tx_out got %b (or empty/done active), expected %b",
                     cur[u].name, k[u] / 16, bad_val[u], cur[u].bits[k[u] / 16]);
          end
          bit_bad[u] = 1'b0;
        end
      end else begin
        tests++;
        if (e !== 1'b1 || d !== 1'b1 || o !== 1'b1) begin
          fails++;
          $display("FAIL %s finish: empty/done/out got %b%b%b, expected 111", cur[u].name, e, d, o);
        end
      end
      k[u]++;
    end
  endtask

  always @(negedge txclk) begin
    mon(0, tx_out0, tx_empty0, tx_done0);
    mon(1, tx_out1, tx_empty1, tx_done1);
  end

  // Called on a negedge: holds the load across exactly one rising edge.
  task automatic load(input int u, input logic [1:0] d);
    if (u == 0) begin ld0 = 1'b1; data0 = d; end
    else        begin ld1 = 1'b1; data1 = d; end
    @(negedge txclk);
    if (u == 0) ld0 = 1'b0;
    else        ld1 = 1'b0;
  endtask

  task automatic wait_done(input int u, input int budget, input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge txclk);
      if ((u == 0 ? tx_done0 : tx_done1) === 1'b1) seen = 1'b1;
    end
    if (!seen) begin
      tests++;
      fails++;
      $display("FAIL %s timeout: tx_done not seen within %0d cycles", name, budget);
    end
  endtask

  initial begin
    int done_before;
    reset = 1'b1;
    ld0 = 1'b0; en0 = 1'b1; data0 = 2'b00;
    ld1 = 1'b0; en1 = 1'b1; data1 = 2'b00;
    for (int u = 0; u < 2; u++) begin
      in_frame[u] = 1'b0; skip[u] = 1'b0; k[u] = 0; bit_bad[u] = 1'b0;
      bad_val[u] = 1'b0; done_cnt[u] = 0; idle_bad[u] = 0;
    end

    repeat (3) @(negedge txclk);
    check("reset tx_out0", tx_out0, 1'b1);
    check("reset tx_empty0", tx_empty0, 1'b1);
    check("reset tx_done0", tx_done0, 1'b0);
    check("reset tx_out1", tx_out1, 1'b1);
    check("reset tx_empty1", tx_empty1, 1'b1);
    check("reset tx_done1", tx_done1, 1'b0);
    #5 reset = 1'b0;
    repeat (2) @(negedge txclk);

    // enable gate: load requests ignored while tx_enable is low
    en0 = 1'b0; ld0 = 1'b1; data0 = 2'b11;
    for (int i = 0; i < 5; i++) begin
      @(negedge txclk);
      check("gate tx_out", tx_out0, 1'b1);
      check("gate tx_empty", tx_empty0, 1'b1);
    end
    ld0 = 1'b0; en0 = 1'b1;
    repeat (3) @(negedge txclk);

    // basic send of 2'b10; tx_data changes right after acceptance
    q0.push_back('{8'b0000_1100, 4, 1'b0, "basic_10"});
    load(0, 2'b10);
    data0 = 2'b01;
    wait_done(0, 80, "basic_10");
    repeat (3) @(negedge txclk);

    // load while busy is ignored: one frame, one done pulse
    done_before = done_cnt[0];
    q0.push_back('{8'b0000_1010, 4, 1'b0, "busy_01"});
    load(0, 2'b01);
    repeat (20) @(negedge txclk);
    load(0, 2'b10);
    wait_done(0, 80, "busy_01");
    repeat (20) @(negedge txclk);
    #1 check("busy single done", (done_cnt[0] - done_before) == 1, 1'b1);

    // back-to-back: load held from late in the frame is taken on the tx_done cycle
    q0.push_back('{8'b0000_1010, 4, 1'b0, "b2b_01"});
    q0.push_back('{8'b0000_1110, 4, 1'b0, "b2b_11"});
    load(0, 2'b01);
    repeat (56) @(negedge txclk);
    ld0 = 1'b1; data0 = 2'b11;
    wait_done(0, 40, "b2b_01");
    @(negedge txclk);
    // line high only for the 16-cycle stop bit plus the single tx_done cycle
    check("b2b start tx_out", tx_out0, 1'b0);
    check("b2b start tx_empty", tx_empty0, 1'b0);
    ld0 = 1'b0;
    wait_done(0, 80, "b2b_11");
    repeat (3) @(negedge txclk);

    // reset mid-frame, asserted between clock edges
    done_before = done_cnt[0];
    q0.push_back('{8'b0000_1100, 4, 1'b1, "abort_10"});
    load(0, 2'b10);
    repeat (30) @(negedge txclk);
    check("pre-reset tx_out", tx_out0, 1'b0);
    #3 reset = 1'b1;
    #1;
    check("async reset tx_out", tx_out0, 1'b1);
    check("async reset tx_empty", tx_empty0, 1'b1);
    check("async reset tx_done", tx_done0, 1'b0);
    #319 reset = 1'b0;
    repeat (2) @(negedge txclk);
    #1 check("abort no done", done_cnt[0] == done_before, 1'b1);
    @(negedge txclk);
    q0.push_back('{8'b0000_1010, 4, 1'b0, "post_reset_01"});
    load(0, 2'b01);
    wait_done(0, 80, "post_reset_01");
    repeat (3) @(negedge txclk);

    // parity instance: 2'b11 -> parity 0, 2'b01 -> parity 1
    q1.push_back('{8'b0001_0110, 5, 1'b0, "par_11"});
    load(1, 2'b11);
    wait_done(1, 100, "par_11");
    repeat (3) @(negedge txclk);
    q1.push_back('{8'b0001_1010, 5, 1'b0, "par_01"});
    load(1, 2'b01);
    wait_done(1, 100, "par_01");
    repeat (5) @(negedge txclk);

    #1;
    check("queue0 drained", q0.size() == 0, 1'b1);
    check("queue1 drained", q1.size() == 0, 1'b1);
    check("unit0 done count 5", done_cnt[0] == 5, 1'b1);
    check("unit1 done count 2", done_cnt[1] == 2, 1'b1);
    check("unit0 idle line high", idle_bad[0] == 0, 1'b1);
    check("unit1 idle line high", idle_bad[1] == 0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

endmodule
